// File: rtl/audio_pwm_out_pkg.sv
// Shared types and constants for the audio PWM output path.
// Holds the sample-fetch FSM state encoding, the volume scaling constants
// and the BCD digit clamp used by the volume scaler.
package audio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CALC1,
      CALC2,
      FULL
   } state_t;

   // duty = (sample * vol_bin * 164) >> 14 maps sample 255 at volume 99 to 252
   localparam int          VOL_SCALE_MUL   = 164;
   localparam int          VOL_SCALE_SHIFT = 14;
   localparam logic [7:0]  PWM_MAX         = 8'd255;
   localparam logic [7:0]  SILENCE_DUTY    = 8'd0;
   localparam logic [3:0]  BCD_MAX         = 4'd9;

   // Non-decimal digit codes (A-F) saturate to 9
   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/audio_pwm_out_bcd_volume_scaler.sv
// Two-stage volume scaler: clamps BCD digits and forms sample*vol_bin, then
// scales the product to an 8-bit PWM duty held until consumed.
// Ports: calc_valid/sample/digit1/digit0 in (stage 1), duty_valid/duty out
// (stage 2, 2 clk after calc_valid); flush drops everything in flight;
// consume clears duty_valid once the duty has been handed to the PWM.
module bcd_volume_scaler
   import audio_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       calc_valid,
   input  logic [7:0] sample,
   input  logic [3:0] digit1,
   input  logic [3:0] digit0,
   input  logic       consume,
   output logic       duty_valid,
   output logic [7:0] duty
);

   logic [3:0]  d1_clamped;
   logic [3:0]  d0_clamped;
   logic [6:0]  vol_bin;
   logic [14:0] prod_next;
   logic        s1_valid;
   logic [14:0] prod;
   logic [22:0] scaled;
   logic [7:0]  duty_next;

   assign d1_clamped = bcd_clamp(digit1);
   assign d0_clamped = bcd_clamp(digit0);
   assign vol_bin    = 7'(d1_clamped) * 7'd10 + 7'(d0_clamped);
   assign prod_next  = 15'(sample) * 15'(vol_bin);

   // 255*99*164 fits in 23 bits, so the scaled product never overflows
   assign scaled    = 23'(prod) * 23'(VOL_SCALE_MUL);
   assign duty_next = 8'(scaled >> VOL_SCALE_SHIFT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         prod       <= '0;
         duty_valid <= 1'b0;
         duty       <= SILENCE_DUTY;
      end else if (flush) begin
         s1_valid   <= 1'b0;
         prod       <= '0;
         duty_valid <= 1'b0;
         duty       <= SILENCE_DUTY;
      end else begin
         s1_valid <= calc_valid;
         if (calc_valid) begin
            prod <= prod_next;
         end
         if (s1_valid) begin
            duty       <= duty_next;
            duty_valid <= 1'b1;
         end else if (consume) begin
            duty_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio PWM output: fetches 8-bit samples over valid/ready, scales them by a
// BCD volume and plays one sample per 256-step PWM period on pwm_out.
// Ports: clk, reset (async, high), play gate, sample_data/valid/ready stream,
// volume1/volume0 BCD digits; outputs pwm_out and a one-clk underrun pulse.
// Only one sample is buffered beyond the one playing; ready is low otherwise.
module audio_pwm_out
   import audio_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play,
   input  logic [7:0] sample_data,
   input  logic       sample_valid,
   output logic       sample_ready,
   input  logic [3:0] volume1,
   input  logic [3:0] volume0,
   output logic       pwm_out,
   output logic       underrun
);

   localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t     state;
   state_t     state_next;
   logic       xfer;

   logic [PSW-1:0] prescaler;
   logic       pwm_tick;
   logic [7:0] pwm_cnt;
   logic       boundary;
   logic [7:0] duty_active;

   logic       cap_valid;
   logic [7:0] cap_sample;
   logic [3:0] cap_d1;
   logic [3:0] cap_d0;

   logic       pend_valid;
   logic [7:0] duty_pending;
   logic       consume;
   logic       starving;

   assign pwm_tick = (prescaler == PSW'(CLK_DIV - 1));
   assign boundary = pwm_tick && (pwm_cnt == PWM_MAX);
   assign consume  = play && boundary && (state == FULL);
   // A result still in the pipeline at a boundary is too late for it
   assign starving = (state == REQ) || (state == CALC1) || (state == CALC2);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ready is gated by play so a word offered on the pause edge is not
   // consumed and then thrown away
   always_comb begin
      state_next   = state;
      sample_ready = 1'b0;
      xfer         = 1'b0;
      if (!play) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:  state_next = REQ;
            REQ: begin
               sample_ready = 1'b1;
               if (sample_valid) begin
                  xfer       = 1'b1;
                  state_next = CALC1;
               end
            end
            CALC1: state_next = CALC2;
            CALC2: state_next = FULL;
            FULL: begin
               if (boundary) begin
                  state_next = REQ;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- prescaler
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if (!play || pwm_tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PSW'(1);
      end
   end

   // ------------------------------------------- counter, duty, capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt     <= '0;
         duty_active <= SILENCE_DUTY;
         pwm_out     <= 1'b0;
         underrun    <= 1'b0;
         cap_valid   <= 1'b0;
         cap_sample  <= '0;
         cap_d1      <= '0;
         cap_d0      <= '0;
      end else if (!play) begin
         // pause restarts the period from zero and drops the in-flight sample
         pwm_cnt     <= '0;
         duty_active <= SILENCE_DUTY;
         pwm_out     <= 1'b0;
         underrun    <= 1'b0;
         cap_valid   <= 1'b0;
      end else begin
         pwm_out   <= (pwm_cnt < duty_active);
         underrun  <= boundary && starving;
         cap_valid <= xfer;
         if (pwm_tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         if (boundary) begin
            if (state == FULL && pend_valid) begin
               duty_active <= duty_pending;
            end else begin
               duty_active <= SILENCE_DUTY;
            end
         end
         // volume is sampled with the data so later volume changes only
         // affect later samples
         if (xfer) begin
            cap_sample <= sample_data;
            cap_d1     <= volume1;
            cap_d0     <= volume0;
         end
      end
   end

   bcd_volume_scaler u_scaler (
      .clk        (clk),
      .reset      (reset),
      .flush      (!play),
      .calc_valid (cap_valid),
      .sample     (cap_sample),
      .digit1     (cap_d1),
      .digit0     (cap_d0),
      .consume    (consume),
      .duty_valid (pend_valid),
      .duty       (duty_pending)
   );

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
Consumer end of the music sample path. It pulls 8-bit unsigned samples from the ROM/address chain over a valid/ready handshake and scales each one by the BCD volume from the volume ASM. It then drives a 1-bit PWM audio pin, one sample per PWM period. It sits between the ROM data bus / ASM_endereco_atual and the board audio output, and is gated by the play/pause FSM output.

Parameters:
- CLK_DIV, default 1: number of clk cycles per PWM counter step; valid range ≥1.
- PWM_BITS, fixed 8: PWM counter width, so one period is 256 steps.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  1 = playing, 0 = paused (from FSM_play_pause)
- sample_data  in  8  unsigned sample word from ROM
- sample_valid  in  1  sample_data is valid
- sample_ready  out  1  block can accept a sample; transfer happens on a rising edge where valid && ready
- volume1  in  4  BCD tens digit of volume
- volume0  in  4  BCD units digit of volume
- pwm_out  out  1  PWM audio output
- underrun  out  1  one-cycle pulse when a PWM period ends with no sample pending

Behaviour:
- Reset (async, active-high): every register clears to 0, including sample_ready, pwm_out, underrun, pwm_cnt, prescaler, duty_active, duty_pending, and the pipeline. FSM goes to IDLE.
- Prescaler:
  - pwm_tick = 1 for one clk every CLK_DIV cycles.
  - pwm_cnt increments on pwm_tick and wraps 255→0.
  - boundary = pwm_tick && pwm_cnt==255.
- pwm_out is registered: pwm_out <= play && (pwm_cnt < duty_active). duty 0 gives constant 0; maximum reachable duty is 252.
- Volume arithmetic (volume captured together with the sample on the transfer edge):
  - Each digit >9 clamps to 9.
  - vol_bin = 10*volume1 + volume0, range 0..99.
  - prod = sample*vol_bin, 15 bits.
  - duty = (prod*164) >> 14, 23-bit intermediate, result truncated to 8 bits.
  - Examples: 200,50→100; 255,99→252; any sample with vol 0 → 0.
- FSM states: IDLE, REQ, CALC1, CALC2, FULL.
  - IDLE: sample_ready=0. Goes to REQ when play=1.
  - REQ: sample_ready=1. On valid&&ready, capture sample and volume, go to CALC1.
  - CALC1: vol_bin and prod registered; go to CALC2.
  - CALC2: duty_pending registered; go to FULL.
  - FULL: at boundary, duty_active <= duty_pending; go to REQ.
  - Latency from transfer edge to duty_pending valid: 2 clk. It applies at the next boundary.
- Boundary while in REQ, CALC1 or CALC2:
  - duty_active <= 0 and underrun=1 for one clk.
  - The in-flight sample continues and is applied at the following boundary.
  - A boundary on the same edge that CALC2 writes duty_pending counts as an underrun.
- sample_ready is high only in REQ, so at most one sample is buffered beyond the active one.
- play=0 (pause), in any state, on the next edge:
  - FSM goes to IDLE.
  - pipeline and duty_pending are discarded.
  - duty_active=0, pwm_cnt=0, prescaler=0, pwm_out=0, no underrun.
- Resume from pause: the first PWM period is silent (duty_active=0). No underrun is reported at the end of that first period if a sample is already pending.
- sample_valid while not in REQ is ignored. No data is consumed and the upstream source must hold the word.
- Volume changes mid-period affect only subsequently transferred samples.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum {IDLE, REQ, CALC1, CALC2, FULL}
  - constants VOL_SCALE_MUL=164, VOL_SCALE_SHIFT=14, PWM_MAX=255, SILENCE_DUTY=0
- One sub-module, bcd_volume_scaler: two-stage pipeline covering BCD clamp, vol_bin, multiply and scale, with a valid-in/valid-out pair.
- The FSM, prescaler, PWM counter and comparator stay in the top module.

Test Plan (CLK_DIV=1):
1. Reset asserted mid-period with play=1 and duty_active=100 → same cycle (async): pwm_out=0, sample_ready=0. After release with play=1: sample_ready=1 one clk later, pwm_cnt starts at 0.
2. play=1, vol=5,0, sample 200 presented in REQ → transfer; sample_ready drops; duty_pending=100 two clk later. Next period: pwm_out high exactly 100 of 256 cycles, underrun never pulses.
3. vol=9,9, sample 255 → 252 high cycles per period. vol=F,F (clamped to 9,9), sample 255 → also 252.
4. vol=0,0 (mute), samples 255 streaming → pwm_out 0 for the entire period, sample_ready still cycles once per period.
5. sample_valid held 0 after one accepted sample → underrun pulses once at each subsequent boundary, pwm_out 0. Raising valid again → the sample is applied at the next boundary, and it is still applied if that boundary coincides with CALC2 (with an underrun pulse on that boundary).
6. play dropped while in CALC1 → next edge: state IDLE, sample_ready=0, pwm_out=0, the pending sample is never output. play raised again → one silent period, then fresh samples only.
